// File: rtl/clk320_ctrl_pkg.sv
// rtl/clk320_ctrl_pkg.sv - shared types and constants for the clk320 generator controller
package clk320_ctrl_pkg;

  localparam int BW = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_GEN = 3'd1,
    WARMUP  = 3'd2,
    RUN     = 3'd3,
    SWEEP   = 3'd4
  } state_t;

  localparam int LVL_BOUND [4] = '{0, 50, 100, 200};

  typedef struct packed {
    logic [1:0]  level;
    logic        sweep;
    logic [15:0] dwell;
  } cfg_t;

  function automatic logic [BW-1:0] lvl_high(input logic [1:0] lvl);
    return BW'(LVL_BOUND[lvl]);
  endfunction

endpackage

// File: rtl/clk320_phase_cnt.sv
// rtl/clk320_phase_cnt.sv - loadable 16-bit down-counter with zero flag
module clk320_phase_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        zero
);

  assign zero = (count == 16'd0);

  // Parks at zero between phases so an idle counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= 16'd0;
    else if (load)  count <= load_val;
    else if (!zero) count <= count - 16'd1;
  end

endmodule

// File: rtl/clk320_gen_ctrl.sv
// rtl/clk320_gen_ctrl.sv - reset/warm-up sequencer and jitter-level scheduler for the 320 MHz generator
module clk320_gen_ctrl
  import clk320_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int WARMUP_CYCLES = 64
) (
  input  logic          clk40,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_level,
  input  logic          cfg_sweep,
  input  logic [15:0]   cfg_dwell,
  input  logic          stop,
  output logic          gen_reset_n,
  output logic          gen_enable,
  output logic [BW-1:0] high,
  output logic [BW-1:0] low,
  output logic [1:0]    level_o,
  output logic [2:0]    state_o,
  output logic          sweep_done
);

  state_t      state;
  cfg_t        cfg_q;
  logic        accept;
  logic        cnt_load;
  logic [15:0] cnt_val;
  logic [15:0] cnt;
  logic        cnt_zero;

  assign cfg_ready = ((state == IDLE) || (state == RUN)) && !stop;
  assign accept    = cfg_valid && cfg_ready;
  assign state_o   = state;

  clk320_phase_cnt u_phase_cnt (
    .clk      (clk40),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Counter loads coincide with the edge that enters the next phase.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = 16'd0;
    if (!stop) begin
      case (state)
        IDLE:    if (accept) begin cnt_load = 1'b1; cnt_val = 16'(RST_CYCLES - 1); end
        RST_GEN: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = 16'(WARMUP_CYCLES - 1); end
        WARMUP:  if (cnt_zero && cfg_q.sweep) begin cnt_load = 1'b1; cnt_val = cfg_q.dwell; end
        RUN:     if (accept && cfg_sweep) begin cnt_load = 1'b1; cnt_val = cfg_dwell; end
        SWEEP:   if (cnt_zero && level_o != 2'd3) begin cnt_load = 1'b1; cnt_val = cfg_q.dwell; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cfg_q       <= '0;
      gen_reset_n <= 1'b0;
      gen_enable  <= 1'b0;
      high        <= '0;
      low         <= '0;
      level_o     <= 2'd0;
      sweep_done  <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (stop) begin
        state       <= IDLE;
        gen_reset_n <= 1'b0;
        gen_enable  <= 1'b0;
        high        <= '0;
        low         <= '0;
        level_o     <= 2'd0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            cfg_q <= '{level: cfg_level, sweep: cfg_sweep, dwell: cfg_dwell};
            state <= RST_GEN;
          end
          RST_GEN: if (cnt_zero) begin
            state       <= WARMUP;
            gen_reset_n <= 1'b1;
            gen_enable  <= 1'b1;
          end
          WARMUP: if (cnt_zero) begin
            if (cfg_q.sweep) begin
              state   <= SWEEP;
              level_o <= 2'd0;
              high    <= lvl_high(2'd0);
              low     <= -lvl_high(2'd0);
            end else begin
              state   <= RUN;
              level_o <= cfg_q.level;
              high    <= lvl_high(cfg_q.level);
              low     <= -lvl_high(cfg_q.level);
            end
          end
          RUN: if (accept) begin
            cfg_q <= '{level: cfg_level, sweep: cfg_sweep, dwell: cfg_dwell};
            if (cfg_sweep) begin
              state   <= SWEEP;
              level_o <= 2'd0;
              high    <= lvl_high(2'd0);
              low     <= -lvl_high(2'd0);
            end else begin
              level_o <= cfg_level;
              high    <= lvl_high(cfg_level);
              low     <= -lvl_high(cfg_level);
            end
          end
          SWEEP: if (cnt_zero) begin
            if (level_o == 2'd3) begin
              state       <= RUN;
              cfg_q.level <= 2'd0;
              level_o     <= 2'd0;
              high        <= lvl_high(2'd0);
              low         <= -lvl_high(2'd0);
              sweep_done  <= 1'b1;
            end else begin
              level_o <= level_o + 2'd1;
              high    <= lvl_high(level_o + 2'd1);
              low     <= -lvl_high(level_o + 2'd1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk320_gen_ctrl.sv
// tb/tb_clk320_gen_ctrl.sv - scoreboard bench for clk320_gen_ctrl
module tb_clk320_gen_ctrl;

  logic        clk40 = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_level = 2'd0;
  logic        cfg_sweep = 1'b0;
  logic [15:0] cfg_dwell = 16'd0;
  logic        stop = 1'b0;
  logic        gen_reset_n, gen_enable, sweep_done;
  logic [10:0] high, low;
  logic [1:0]  level_o;
  logic [2:0]  state_o;

  clk320_gen_ctrl dut (
    .clk40(clk40), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_level(cfg_level), .cfg_sweep(cfg_sweep), .cfg_dwell(cfg_dwell), .stop(stop),
    .gen_reset_n(gen_reset_n), .gen_enable(gen_enable), .high(high), .low(low),
    .level_o(level_o), .state_o(state_o), .sweep_done(sweep_done)
  );

  always #12 clk40 = ~clk40;

  int cyc = 0;
  always @(posedge clk40) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       nm;
    logic [2:0]  st;
    logic        rn, en, dn, rdy;
    logic [10:0] hi, lo;
    logic [1:0]  lv;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int bound_tab [4] = '{0, 50, 100, 200};

  task automatic push(input int c, input string nm, input logic [2:0] st,
                      input logic [1:0] lv, input logic dn, input logic rdy);
    exp_t e;
    e.cyc = c; e.nm = nm; e.st = st; e.lv = lv; e.dn = dn; e.rdy = rdy;
    e.rn = (st >= 3'd2);
    e.en = (st >= 3'd2);
    e.hi = (st >= 3'd3) ? 11'(bound_tab[lv]) : 11'd0;
    e.lo = 11'(-e.hi);
    q.push_back(e);
  endtask

  // Monitor: compares the full output snapshot for every cycle that has an expectation.
  always @(negedge clk40) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s missed: expected at cyc %0d, now %0d", e.nm, e.cyc, cyc);
      end else if (state_o !== e.st || gen_reset_n !== e.rn || gen_enable !== e.en ||
                   high !== e.hi || low !== e.lo || level_o !== e.lv ||
                   sweep_done !== e.dn || cfg_ready !== e.rdy) begin
        bad++;
        $display("FAIL %s cyc=%0d got st=%0d rn=%b en=%b hi=%0d lo=%0d lv=%0d dn=%b rdy=%b want st=%0d rn=%b en=%b hi=%0d lo=%0d lv=%0d dn=%b rdy=%b",
                 e.nm, cyc, state_o, gen_reset_n, gen_enable, $signed(high), $signed(low),
                 level_o, sweep_done, cfg_ready, e.st, e.rn, e.en, $signed(e.hi),
                 $signed(e.lo), e.lv, e.dn, e.rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic send(input logic [1:0] lv, input logic sw, input logic [15:0] dw);
    cfg_valid = 1'b1; cfg_level = lv; cfg_sweep = sw; cfg_dwell = dw;
  endtask

  initial begin : stim
    int k;
    tick(); tick();
    push(cyc, "reset_held", 3'd0, 2'd0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    tick();

    // Cold start to static level 2
    k = cyc;
    send(2'd2, 1'b0, 16'd0);
    push(k,      "idle_pre",   3'd0, 2'd0, 1'b0, 1'b1);
    push(k + 1,  "rst_first",  3'd1, 2'd0, 1'b0, 1'b0);
    push(k + 8,  "rst_last",   3'd1, 2'd0, 1'b0, 1'b0);
    push(k + 9,  "warm_first", 3'd2, 2'd0, 1'b0, 1'b0);
    push(k + 72, "warm_last",  3'd2, 2'd0, 1'b0, 1'b0);
    push(k + 73, "run_l2",     3'd3, 2'd2, 1'b0, 1'b1);
    tick();
    cfg_valid = 1'b0;
    wait_until(k + 74);

    // Static change in RUN
    k = cyc;
    send(2'd3, 1'b0, 16'd0);
    push(k,     "run_pre_l3", 3'd3, 2'd2, 1'b0, 1'b1);
    push(k + 1, "run_l3",     3'd3, 2'd3, 1'b0, 1'b1);
    tick();
    cfg_valid = 1'b0;
    tick();

    // Sweep with dwell 4
    k = cyc;
    send(2'd1, 1'b1, 16'd4);
    for (int i = 0; i < 20; i++)
      push(k + 1 + i, $sformatf("sweep4_%0d", i), 3'd4, 2'(i / 5), 1'b0, 1'b0);
    push(k + 21, "sweep4_end",  3'd3, 2'd0, 1'b1, 1'b1);
    push(k + 22, "sweep4_once", 3'd3, 2'd0, 1'b0, 1'b1);
    tick();
    cfg_valid = 1'b0;
    wait_until(k + 23);

    // stop and cfg_valid together in RUN
    k = cyc;
    send(2'd1, 1'b0, 16'd0);
    stop = 1'b1;
    push(k,     "stop_rdy",  3'd3, 2'd0, 1'b0, 1'b0);
    push(k + 1, "stop_idle", 3'd0, 2'd0, 1'b0, 1'b1);
    tick();
    stop = 1'b0;
    cfg_valid = 1'b0;
    tick();

    // Reset during WARMUP, then full restart
    k = cyc;
    send(2'd1, 1'b0, 16'd0);
    push(k + 20, "warm_mid", 3'd2, 2'd0, 1'b0, 1'b0);
    push(k + 21, "async_rst", 3'd0, 2'd0, 1'b0, 1'b1);
    tick();
    cfg_valid = 1'b0;
    wait_until(k + 21);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    k = cyc;
    send(2'd1, 1'b0, 16'd0);
    push(k + 1,  "rerst_first", 3'd1, 2'd0, 1'b0, 1'b0);
    push(k + 8,  "rerst_last",  3'd1, 2'd0, 1'b0, 1'b0);
    push(k + 9,  "rewarm",      3'd2, 2'd0, 1'b0, 1'b0);
    push(k + 73, "rerun_l1",    3'd3, 2'd1, 1'b0, 1'b1);
    tick();
    cfg_valid = 1'b0;
    wait_until(k + 74);

    // Sweep with dwell 0
    k = cyc;
    send(2'd2, 1'b1, 16'd0);
    for (int i = 0; i < 4; i++)
      push(k + 1 + i, $sformatf("sweep0_%0d", i), 3'd4, 2'(i), 1'b0, 1'b0);
    push(k + 5, "sweep0_end",  3'd3, 2'd0, 1'b1, 1'b1);
    push(k + 6, "sweep0_once", 3'd3, 2'd0, 1'b0, 1'b1);
    tick();
    cfg_valid = 1'b0;
    wait_until(k + 8);

    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/clk320_gen_ctrl.md
# clk320_gen_ctrl

Sequencer and jitter-level scheduler for the 320 MHz clock generator in the ETROC2 readout fast-command path. It runs on clk40 and brings the generator out of reset through a fixed reset/warm-up sequence. It then drives the generator's signed jitter bounds, either from a static level or from an automatic sweep over all four levels. Configuration arrives from slow control through a valid/ready handshake.

## Interface
- RST_CYCLES, 8: clk40 cycles gen_reset_n is held low at start.
- WARMUP_CYCLES, 64: clk40 cycles with generator enabled and bounds forced to 0 before bounds are applied.
- BW, 11: width of the signed bound outputs, in ps.
- clk40  in  1  system clock, 40 MHz.
- reset  in  1  asynchronous, active-high.
- cfg_valid  in  1  configuration word valid.
- cfg_ready  out  1  controller accepts a word this cycle.
- cfg_level  in  2  static jitter level, 0..3.
- cfg_sweep  in  1  1 = sweep levels 0..3 instead of holding cfg_level.
- cfg_dwell  in  16  sweep dwell per level; dwell = cfg_dwell+1 cycles.
- stop  in  1  single-cycle request to abort and return to IDLE.
- gen_reset_n  out  1  generator reset, active-low.
- gen_enable  out  1  generator enable.
- high  out  BW  signed upper jitter bound, ps.
- low  out  BW  signed lower jitter bound, ps.
- level_o  out  2  level currently applied.
- state_o  out  3  current FSM state encoding.
- sweep_done  out  1  one-cycle pulse when a sweep completes.

## Operation
- States: IDLE=0, RST_GEN=1, WARMUP=2, RUN=3, SWEEP=4.
- Level table gives high/low per level: L0 = +0/−0, L1 = +50/−50, L2 = +100/−100, L3 = +200/−200. low is always the two's-complement negation of high.
- cfg_ready = (state is IDLE or RUN) & ~stop. A word is accepted on cfg_valid & cfg_ready and latched into internal cfg registers.
- IDLE: gen_reset_n=0, gen_enable=0, bounds 0. An accepted word moves to RST_GEN.
- RST_GEN: gen_reset_n=0, gen_enable=0. Runs for RST_CYCLES cycles, then goes to WARMUP.
- WARMUP: gen_reset_n=1, gen_enable=1, bounds 0. Runs for WARMUP_CYCLES cycles. Then goes to SWEEP if the latched cfg_sweep=1, otherwise to RUN.
- RUN: bounds come from the table at the latched level. An accepted word with sweep=0 changes the level in place, with no re-reset. An accepted word with sweep=1 enters SWEEP.
- SWEEP: level starts at 0 and the dwell counter loads cfg_dwell. Each time the counter reaches 0, the level increments and the counter reloads. After the L3 dwell expires: pulse sweep_done, go to RUN with latched level set to 0.
- stop is honoured in any state and moves to IDLE on the next edge. stop outranks cfg_valid in the same cycle; that word is not accepted.
- Counters are 16-bit, unsigned, saturate-free. Phase counters load on state entry.

## Timing
- All outputs are registered. On reset assertion they immediately take: gen_reset_n=0, gen_enable=0, high=0, low=0, level_o=0, state_o=IDLE, sweep_done=0. cfg_ready is 1 in IDLE after reset.
- Accept in IDLE at edge N:
  - state_o=RST_GEN from N+1.
  - gen_reset_n rises at N+1+RST_CYCLES.
  - Bounds become valid at N+1+RST_CYCLES+WARMUP_CYCLES.
- Static level change in RUN: high/low/level_o update one edge after acceptance.
- Sweep: each level is held exactly cfg_dwell+1 cycles. The sweep_done pulse coincides with the first RUN cycle. cfg_dwell=0 gives 1 cycle per level.
- Reset mid-operation abandons the sequence. Outputs return to their reset values asynchronously.

## Structure
- Package clk320_ctrl_pkg holds:
  - the state enum;
  - BW;
  - the level-bound constants LVL_BOUND[0..3] = {0, 50, 100, 200};
  - a cfg struct with fields level, sweep, dwell.
- One sub-module, clk320_phase_cnt: a loadable 16-bit down-counter with a zero flag. It is shared by RST_GEN, WARMUP and the SWEEP dwell.

## Test plan
- Reset release, then cfg (level=2, sweep=0) → gen_reset_n low 8 cycles, enable high, 64 cycles of 0 bounds, then high=+100, low=−100, state_o=3.
- In RUN, cfg level=3 → high=+200, low=−200 one cycle later; gen_reset_n stays 1.
- cfg (sweep=1, dwell=4) → levels 0,1,2,3 each held 5 cycles. sweep_done pulses once. RUN at level 0 with bounds 0.
- stop and cfg_valid asserted in the same cycle in RUN → no accept, IDLE next cycle, gen_enable=0, bounds 0.
- Assert reset during WARMUP → outputs immediately at reset values. Re-config restarts the full RST_GEN sequence.
- Sweep with dwell=0 → each level held exactly 1 cycle, sweep_done 4 cycles after SWEEP entry.
